serial_addsub: RTL and testbench

Bit-serial N-bit adder/subtractor built around a single full-adder cell and a registered carry. It processes operands LSB-first, one bit per clock. It is the sequential counterpart to the combinational full-adder cells and reuses the same sum/carry equations. It sits between a simple controller and a result register, with a start/busy/done handshake.

---
 rtl/serial_addsub.sv | 133 +++++++++++++
 tb/tb_serial_addsub.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// ============================================================================
// Module   : serial_addsub
// Brief    : Bit-serial WIDTH-bit adder/subtractor, LSB first, one full-adder
//            cell with a registered carry and a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] r_sh_q,   r_sh_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic             c_msb_q,  c_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             co_q,     co_d;
    logic             ovf_q,    ovf_d;

    logic             w_sum;
    logic             w_cout;
    logic             w_accept;
    logic [WIDTH-1:0] w_r_next;

    // Single full-adder cell operating on the current LSBs.
    assign w_sum    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign w_cout   = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign w_r_next = {w_sum, r_sh_q[WIDTH-1:1]};
    assign w_accept = start && (state_q != S_RUN);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        c_msb_d  = c_msb_q;
        result_d = result_q;
        co_d     = co_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_RUN: begin
                carry_d = w_cout;
                r_sh_d  = w_r_next;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_PENULT) begin
                    c_msb_d = w_cout;
                end
                if (cnt_q == CNT_LAST) begin
                    result_d = w_r_next;
                    co_d     = w_cout;
                    ovf_d    = c_msb_q ^ w_cout;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (w_accept) begin
                    // Subtraction is a + ~b + 1; the +1 enters as initial carry.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            result_q <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            c_msb_q  <= c_msb_d;
            result_q <= result_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign co     = co_q;
    assign ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// Module   : tb_serial_addsub
// Brief    : Directed vector bench for serial_addsub (WIDTH=8 and WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

    logic       clk;
    logic       rst;
    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, co8, ovf8;
    logic [7:0] result8;
    logic       start4, sub4;
    logic [3:0] a4, b4;
    logic       busy4, done4, co4, ovf4;
    logic [3:0] result4;

    int tests = 0;
    int fails = 0;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .co(co8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4), .co(co4), .ovf(ovf4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       s;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
        logic       c;
        logic       v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Word-level reference: returns {result, co, ovf} packed as (r<<2)|(co<<1)|ovf.
    function automatic int model(input int w, input int s, input int x, input int y);
        int mask, bb, sum, r, c, v, msb;
        mask = (1 << w) - 1;
        msb  = w - 1;
        bb   = (s != 0) ? (~y & mask) : (y & mask);
        sum  = (x & mask) + bb + s;
        r    = sum & mask;
        c    = (sum >> w) & 1;
        v    = ((((x >> msb) & 1) == ((bb >> msb) & 1)) && (((r >> msb) & 1) != ((x >> msb) & 1))) ? 1 : 0;
        return (r << 2) | (c << 1) | v;
    endfunction

    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] r, output logic c, output logic v,
                       output int lat, output int nbusy, output logic busy_at_done);
        @(negedge clk);
        start8 = 1'b1; sub8 = s; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0; sub8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 1; nbusy = 0;
        while (!done8 && lat < 40) begin
            if (busy8) nbusy++;
            @(negedge clk);
            lat++;
        end
        r = result8; c = co8; v = ovf8; busy_at_done = busy8;
    endtask

    task automatic op4(input logic s, input logic [3:0] x, input logic [3:0] y,
                       output logic [3:0] r, output logic c, output logic v, output int lat);
        @(negedge clk);
        start4 = 1'b1; sub4 = s; a4 = x; b4 = y;
        @(negedge clk);
        start4 = 1'b0; sub4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 1;
        while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = result4; c = co4; v = ovf4;
    endtask

    initial begin
        vec_t       vec [10];
        logic [7:0] r8;
        logic [3:0] r4;
        logic       c, v, bd, hold_ok, seen;
        int         lat, nbusy, exp, idx;
        logic [7:0] bx [6];
        logic [7:0] by [6];
        logic       bs [6];

        vec[0] = '{1'b0, 8'h3C, 8'h5A, 8'h96, 1'b0, 1'b1};
        vec[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vec[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vec[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vec[4] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vec[5] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vec[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vec[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
        vec[8] = '{1'b1, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1};
        vec[9] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};

        bs[0] = 1'b0; bx[0] = 8'h11; by[0] = 8'h22;
        bs[1] = 1'b1; bx[1] = 8'h40; by[1] = 8'h41;
        bs[2] = 1'b0; bx[2] = 8'hC0; by[2] = 8'hC0;
        bs[3] = 1'b1; bx[3] = 8'h7F; by[3] = 8'h80;
        bs[4] = 1'b0; bx[4] = 8'h64; by[4] = 8'h64;
        bs[5] = 1'b1; bx[5] = 8'hFF; by[5] = 8'hFF;

        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;

        // Reset state
        @(negedge clk);
        check("reset_busy",   {31'd0, busy8},  32'd0);
        check("reset_done",   {31'd0, done8},  32'd0);
        check("reset_result", {24'd0, result8}, 32'd0);
        check("reset_co_ovf", {30'd0, co8, ovf8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            op8(vec[i].s, vec[i].x, vec[i].y, r8, c, v, lat, nbusy, bd);
            check($sformatf("vec%0d_result", i), {24'd0, r8}, {24'd0, vec[i].r});
            check($sformatf("vec%0d_co", i),     {31'd0, c},  {31'd0, vec[i].c});
            check($sformatf("vec%0d_ovf", i),    {31'd0, v},  {31'd0, vec[i].v});
            check($sformatf("vec%0d_latency", i), lat, 32'd9);
            check($sformatf("vec%0d_busy_cycles", i), nbusy, 32'd8);
            check($sformatf("vec%0d_busy_at_done", i), {31'd0, bd}, 32'd0);
        end

        // Start while busy is ignored; previous result (0x7F) holds during RUN
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h10; b8 = 8'h20;
        hold_ok = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start8 = (cyc == 3);
            a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0;
            if (result8 !== 8'h7F || co8 !== 1'b1 || ovf8 !== 1'b1 || busy8 !== 1'b1) hold_ok = 1'b0;
        end
        @(negedge clk);
        start8 = 1'b0;
        check("ign_hold_during_run", {31'd0, hold_ok}, 32'd1);
        check("ign_done_cycle9", {31'd0, done8}, 32'd1);
        check("ign_result", {24'd0, result8}, 32'h30);
        @(negedge clk);
        check("ign_no_extra_run", {30'd0, busy8, done8}, 32'd0);

        // Reset mid-RUN aborts without done
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_result", {24'd0, result8}, 32'd0);
        check("rst_co_ovf", {30'd0, co8, ovf8}, 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        check("rst_no_done", {31'd0, seen}, 32'd0);
        op8(1'b0, 8'h01, 8'h01, r8, c, v, lat, nbusy, bd);
        check("post_rst_result", {24'd0, r8}, 32'h02);
        check("post_rst_latency", lat, 32'd9);

        // Back-to-back with start held high
        idx = 0;
        for (int cyc = 0; cyc <= 9 * 6 + 1; cyc++) begin
            @(negedge clk);
            if (done8) begin
                check("b2b_done_cycle", cyc, 9 * (idx + 1));
                if (idx < 6) begin
                    exp = model(8, int'(bs[idx]), int'(bx[idx]), int'(by[idx]));
                    check($sformatf("b2b%0d_res_co_ovf", idx), {22'd0, result8, co8, ovf8}, exp);
                end
                idx++;
            end
            if (cyc % 9 == 0 && cyc / 9 < 6) begin
                start8 = 1'b1; sub8 = bs[cyc / 9]; a8 = bx[cyc / 9]; b8 = by[cyc / 9];
            end else if (cyc % 9 == 0) begin
                start8 = 1'b0;
            end else begin
                sub8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        check("b2b_done_count", idx, 32'd6);

        // WIDTH=4 exhaustive sweep
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    op4(1'(s), 4'(x), 4'(y), r4, c, v, lat);
                    exp = model(4, s, x, y);
                    check($sformatf("w4_s%0d_a%0h_b%0h", s, x, y),
                          {22'd0, lat[3:0], r4, c, v}, {22'd0, 4'd5, exp[5:0]});
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
